dmem_access_unit: RTL and testbench

- Load/store front-end between the CPU memory stage and the word-only data memory (32-bit words, 1024 entries, word index addr[11:2], combinational read, write on posedge clk).
- Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:
  - Sub-word loads are extracted and extended in this block.
  - Sub-word stores are done as read-modify-write.
  - Misaligned or illegal accesses are rejected with an error and never touch memory.

---
 rtl/dmem_access_unit_if.sv | 33 +++
 rtl/dmem_access_unit.sv | 138 +++++++++++++
 tb/tb_dmem_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Request/response channel between the CPU memory stage and dmem_access_unit.
// The CPU side drives requests as master; the access unit answers as slave.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface dmem_access_unit_if #(
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int DATA_W = `WORD_LEN
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_access_unit.sv
// RV32I load/store front-end for a word-only data memory: sub-word loads are
// extracted here, sub-word stores become read-modify-write, bad accesses error out.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module dmem_access_unit #(
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int DATA_W = `WORD_LEN
) (
  input  logic              clk,
  input  logic              reset,
  dmem_access_unit_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_writeEnable,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              req_legal;
  logic              req_misaligned;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    if (bus.req_write)
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    else
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
    if (bus.req_funct3[1:0] == 2'b01)
      req_misaligned = bus.req_addr[0];
    else if (bus.req_funct3[1:0] == 2'b10)
      req_misaligned = (bus.req_addr[1:0] != 2'b00);
  end

  always_comb begin
    shifted   = mem_readData >> {addr_q[1:0], 3'b000};
    byte_lane = shifted[7:0];
    half_lane = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_data = mem_readData;
      3'b100:  load_data = {24'h0, byte_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = '0;
    endcase
  end

  // wdata_q still holds the raw store data when MERGE reads it
  always_comb begin
    merged = mem_readData;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = mem_readData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (!req_legal || req_misaligned) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else if (!bus.req_write)
              state <= S_LOAD;
            else if (bus.req_funct3 == 3'b010)
              state <= S_WRITE;
            else
              state <= S_MERGE;
          end
        end
        S_LOAD: begin
          rdata_q <= load_data;
          state   <= S_RESP;
        end
        S_MERGE: begin
          wdata_q <= merged;
          state   <= S_WRITE;
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gating with reset keeps an aborted store from landing in memory
  assign mem_writeEnable = (state == S_WRITE) && !reset;
  assign mem_writeData   = wdata_q;
  assign mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.req_ready   = (state == S_IDLE);
  assign bus.resp_valid  = (state == S_RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural word memory and a
// scoreboard of expected responses.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_writeEnable;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;
  logic [31:0] dmem [0:1023] = '{default: 32'h0};

  int compared = 0;
  int mismatched = 0;
  int write_count = 0;
  int resp_count = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;
  exp_t sb_q[$];

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .mem_addr        (mem_addr),
    .mem_writeEnable (mem_writeEnable),
    .mem_writeData   (mem_writeData),
    .mem_readData    (mem_readData)
  );

  always #5 clk = ~clk;

  assign mem_readData = dmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_writeEnable) begin
      dmem[mem_addr[11:2]] <= mem_writeData;
      write_count <= write_count + 1;
    end
    if (bus.resp_valid) resp_count <= resp_count + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then wait a bounded number of cycles for its response
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input bit hold);
    exp_t e;
    int   w0;
    int   lat;
    bit   found;
    @(negedge clk);
    checkOutput({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, " idle resp_valid"}, 32'(bus.resp_valid), 32'd0);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.writes = (wr && !exp_err) ? 1 : 0;
    sb_q.push_back(e);
    w0 = write_count;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    found = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6 && !found; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        found = 1'b1;
        lat = c;
      end
    end
    checkOutput({tag, " resp seen"}, 32'(found), 32'd1);
    e = sb_q.pop_front();
    if (found) begin
      checkOutput({tag, " rdata"}, bus.resp_rdata, e.rdata);
      checkOutput({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
      checkOutput({tag, " latency"}, lat, e.lat);
      checkOutput({tag, " writes"}, write_count - w0, e.writes);
      checkOutput({tag, " ready in resp"}, 32'(bus.req_ready), 32'd0);
    end
  endtask

  initial begin
    int w0;
    int r0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("reset mem_we", 32'(mem_writeEnable), 32'd0);
    checkOutput("reset mem_wdata", mem_writeData, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    applyStimulus("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    checkOutput("dmem[4] after SW", dmem[4], 32'hDEADBEEF);

    applyStimulus("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b0);
    applyStimulus("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1'b0);
    applyStimulus("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1'b0);
    applyStimulus("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b0);
    applyStimulus("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

    applyStimulus("SB 0x11", 1'b1, 3'b000, 32'h11, 32'h123456AA, 32'h0, 1'b0, 3, 1'b0);
    checkOutput("dmem[4] after SB", dmem[4], 32'hDEADAAEF);
    applyStimulus("SH 0x12", 1'b1, 3'b001, 32'h12, 32'h00005555, 32'h0, 1'b0, 3, 1'b0);
    checkOutput("dmem[4] after SH", dmem[4], 32'h5555AAEF);

    applyStimulus("LW misaligned",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("SH misaligned",  1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("load f3 011",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("store f3 100",   1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b0);
    applyStimulus("LH misaligned",  1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("dmem[4] after errors", dmem[4], 32'h5555AAEF);

    // Reset during the MERGE cycle of an SB
    @(negedge clk);
    w0 = write_count;
    r0 = resp_count;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("SB abort ready", 32'(bus.req_ready), 32'd1);
    checkOutput("SB abort resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("SB abort writes", write_count - w0, 32'd0);
    checkOutput("SB abort resps", resp_count - r0, 32'd0);
    checkOutput("SB abort dmem[16]", dmem[16], 32'h0);

    // Reset during the WRITE cycle of an SW
    @(negedge clk);
    w0 = write_count;
    r0 = resp_count;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h11111111;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("SW abort mem_we gated", 32'(mem_writeEnable), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("SW abort ready", 32'(bus.req_ready), 32'd1);
    checkOutput("SW abort resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("SW abort writes", write_count - w0, 32'd0);
    checkOutput("SW abort resps", resp_count - r0, 32'd0);
    checkOutput("SW abort dmem[8]", dmem[8], 32'h0);

    // req_valid held high across three back-to-back requests
    w0 = write_count;
    r0 = resp_count;
    applyStimulus("held SW 0x30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
    applyStimulus("held SB 0x31", 1'b1, 3'b000, 32'h31, 32'h000000BB, 32'h0, 1'b0, 3, 1'b1);
    applyStimulus("held LW 0x30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEBB0D, 1'b0, 2, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("held final ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("held writes", write_count - w0, 32'd2);
    checkOutput("held resps", resp_count - r0, 32'd3);
    checkOutput("held dmem[12]", dmem[12], 32'hCAFEBB0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
